dp_mem_responder: RTL and testbench

Memory-side responder for the datapath-to-cache request interface: accepts the datapath's instruction-fetch and data load/store requests, serialises them onto a single-ported RAM with variable wait states, and returns `ihit`/`dhit` with load data. Sits between the datapath and the RAM model, replacing a zero-latency stub. Data requests take priority over instruction fetches, and `halt` freezes the block.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/mem_resp_pkg.sv | 33 +++
 rtl/dp_ibuf.sv | 55 +++++
 rtl/dp_mem_responder.sv | 152 +++++++++++++++
 tb/tb_dp_mem_responder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : Machine word and byte-address types shared by the datapath and the
//           memory-side blocks.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : cpu_types_pkg

// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Purpose : State encoding and latched-request layout for dp_mem_responder.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package mem_resp_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    DHIT = 3'd3,
    IHIT = 3'd4,
    HALT = 3'd5
  } mem_state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_IREAD  = 2'd1,
    OP_DREAD  = 2'd2,
    OP_DWRITE = 2'd3
  } mem_op_t;

  // Request captured on entry to DACC/IACC; the datapath inputs are ignored
  // from then until the access completes.
  typedef struct packed {
    mem_op_t op;
    addr_t   addr;
    word_t   data;
  } mem_req_t;

endpackage : mem_resp_pkg

// File: rtl/dp_ibuf.sv
// -----------------------------------------------------------------------------
// dp_ibuf
// Purpose : One-entry instruction buffer (tag, data, valid) used by
//           dp_mem_responder when DP_IBUF_EN is defined.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           lookup_addr_i     - fetch address compared against the tag
//           hit_o/hit_data_o  - tag match with valid entry, buffered word
//           fill_i/fill_*_i   - refill from a completed instruction access
//           inval_i/inval_addr_i - data write; clears valid on tag match
// -----------------------------------------------------------------------------
module dp_ibuf #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [WORD_W-1:0] hit_data_o,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [WORD_W-1:0] fill_data_i,
  input  logic              inval_i,
  input  logic [ADDR_W-1:0] inval_addr_i
);

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [WORD_W-1:0] data_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
    end else if (inval_i && (inval_addr_i == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: tag and data carry no reset; they are meaningless while valid_q is
  // low, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q  <= fill_addr_i;
      data_q <= fill_data_i;
    end
  end

  assign hit_o      = valid_q && (tag_q == lookup_addr_i);
  assign hit_data_o = data_q;

endmodule : dp_ibuf

// File: rtl/dp_mem_responder.sv
// -----------------------------------------------------------------------------
// dp_mem_responder
// Purpose : Memory-side responder for the datapath request interface. Accepts
//           instruction fetches and data loads/stores, serialises them onto a
//           single-ported RAM with wait states, and returns one-cycle
//           ihit/dhit pulses with load data. Data requests beat fetches;
//           halt parks the block in HALT until RST.
// Config  : DP_IBUF_EN - compiles in a one-entry instruction buffer (dp_ibuf)
//           that answers a repeat fetch in one cycle without a RAM access.
// Ports   : CLK, RST (async, active-high)
//           imemREN/imemaddr -> ihit/imemload          (instruction side)
//           dmemREN/dmemWEN/dmemaddr/dmemstore -> dhit/dmemload (data side)
//           halt -> halted
//           ram_ren/ram_wen/ram_addr/ram_store, ram_load/ram_ready (RAM side)
// Request/response registers use cpu_types_pkg word and address types, so
// WORD_W/ADDR_W must match that package.
// -----------------------------------------------------------------------------
module dp_mem_responder
  import cpu_types_pkg::*;
  import mem_resp_pkg::*;
#(
  parameter int WORD_W = cpu_types_pkg::WORD_W,
  parameter int ADDR_W = cpu_types_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  input  logic              halt,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              dhit,
  output logic [WORD_W-1:0] dmemload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              halted
);

  mem_state_t state_q, state_d;
  mem_req_t   req_q, req_d;
  word_t      resp_q, resp_d;
  logic       access;
  logic       ibuf_take;
  word_t      ibuf_data;

`ifdef DP_IBUF_EN
  logic ibuf_hit;
  logic ibuf_fill;
  logic ibuf_inval;

  assign ibuf_fill  = (state_q == IACC) && ram_ready;
  assign ibuf_inval = (state_q == DACC) && ram_ready && (req_q.op == OP_DWRITE);
  assign ibuf_take  = imemREN && ibuf_hit;

  dp_ibuf #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) u_ibuf (
    .clk          (CLK),
    .rst          (RST),
    .lookup_addr_i(imemaddr),
    .hit_o        (ibuf_hit),
    .hit_data_o   (ibuf_data),
    .fill_i       (ibuf_fill),
    .fill_addr_i  (req_q.addr),
    .fill_data_i  (ram_load),
    .inval_i      (ibuf_inval),
    .inval_addr_i (req_q.addr)
  );
`else
  assign ibuf_take = 1'b0;
  assign ibuf_data = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALT;
        end else if (dmemWEN || dmemREN) begin
          state_d    = DACC;
          req_d.op   = dmemWEN ? OP_DWRITE : OP_DREAD;  // write wins
          req_d.addr = dmemaddr;
          req_d.data = dmemstore;
        end else if (ibuf_take) begin
          state_d = IHIT;
          resp_d  = ibuf_data;
        end else if (imemREN) begin
          state_d    = IACC;
          req_d.op   = OP_IREAD;
          req_d.addr = imemaddr;
          req_d.data = dmemstore;
        end
      end
      DACC: begin
        if (ram_ready) begin
          state_d = DHIT;
          resp_d  = (req_q.op == OP_DWRITE) ? '0 : ram_load;
        end
      end
      IACC: begin
        if (ram_ready) begin
          state_d = IHIT;
          resp_d  = ram_load;
        end
      end
      // The datapath's old request is still up during a hit, so it is not
      // sampled; the next request is seen in the following IDLE cycle.
      DHIT, IHIT: state_d = IDLE;
      HALT:       state_d = HALT;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs decode only from registered state; no input reaches an output.
  assign access    = (state_q == DACC) || (state_q == IACC);
  assign ram_ren   = access && ((req_q.op == OP_IREAD) || (req_q.op == OP_DREAD));
  assign ram_wen   = access && (req_q.op == OP_DWRITE);
  assign ram_addr  = access ? req_q.addr : '0;
  assign ram_store = access ? req_q.data : '0;
  assign ihit      = (state_q == IHIT);
  assign dhit      = (state_q == DHIT);
  assign imemload  = ihit ? resp_q : '0;
  assign dmemload  = dhit ? resp_q : '0;
  assign halted    = (state_q == HALT);

endmodule : dp_mem_responder

// File: tb/tb_dp_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dp_mem_responder
// Purpose : Directed self-checking bench for dp_mem_responder. Inputs change
//           1 time unit after a rising edge; outputs are compared there too.
// -----------------------------------------------------------------------------
module tb_dp_mem_responder;
  import mem_resp_pkg::*;

  logic        CLK, RST;
  logic        imemREN, dmemREN, dmemWEN, halt, ram_ready;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ram_load;
  logic        ihit, dhit, ram_ren, ram_wen, halted;
  logic [31:0] imemload, dmemload, ram_addr, ram_store;

  int total = 0;
  int bad   = 0;

  dp_mem_responder dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready),
    .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    imemREN = 0; dmemREN = 0; dmemWEN = 0; halt = 0; ram_ready = 0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ram_load = '0;
  endtask

  task automatic test_reset();
    logic [164:0] all_out;
    idle_inputs();
    RST = 1'b1;
    #1;
    all_out = {ihit, dhit, ram_ren, ram_wen, halted, imemload, dmemload, ram_addr, ram_store};
    if (all_out !== '0) begin bad++; $display("FAIL rst_outputs got=%h want=0", all_out); end
    total++;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    if (dut.state_q !== IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dut.state_q, IDLE); end
    total++;
    // Start a data read, then reset while the RAM strobe is up.
    dmemREN = 1; dmemaddr = 32'h80;
    tick();
    if (ram_ren !== 1'b1) begin bad++; $display("FAIL rst_dacc_ren got=%b want=1", ram_ren); end
    total++;
    #2 RST = 1'b1;
    #1;
    all_out = {ihit, dhit, ram_ren, ram_wen, halted, imemload, dmemload, ram_addr, ram_store};
    if (all_out !== '0) begin bad++; $display("FAIL rst_async_outputs got=%h want=0", all_out); end
    total++;
    dmemREN = 0;
    tick();
    RST = 1'b0;
    ram_ready = 1; ram_load = 32'h1;
    tick();
    if ({dhit, ihit, ram_ren} !== 3'b000) begin bad++; $display("FAIL rst_no_hit got=%b want=000", {dhit, ihit, ram_ren}); end
    total++;
    if (dut.state_q !== IDLE) begin bad++; $display("FAIL rst_after_state got=%0d want=%0d", dut.state_q, IDLE); end
    total++;
    ram_ready = 0;
  endtask

  task automatic test_zero_wait_fetch();
    imemREN = 1; imemaddr = 32'h4; ram_ready = 1; ram_load = 32'h8C22_0000;
    tick();  // cycle 1: IACC
    if ({ram_ren, ihit} !== 2'b10) begin bad++; $display("FAIL zw_c1 ren_ihit got=%b want=10", {ram_ren, ihit}); end
    total++;
    if (ram_addr !== 32'h4) begin bad++; $display("FAIL zw_addr got=%h want=00000004", ram_addr); end
    total++;
    tick();  // cycle 2: IHIT
    if ({ihit, ram_ren} !== 2'b10) begin bad++; $display("FAIL zw_c2 ihit_ren got=%b want=10", {ihit, ram_ren}); end
    total++;
    if (imemload !== 32'h8C22_0000) begin bad++; $display("FAIL zw_data got=%h want=8c220000", imemload); end
    total++;
    imemREN = 0; ram_ready = 0;
    tick();
    if ({ihit, imemload} !== 33'h0) begin bad++; $display("FAIL zw_c3 ihit=%b load=%h want 0", ihit, imemload); end
    total++;
  endtask

  task automatic test_priority_wait();
    imemREN = 1; imemaddr = 32'h8;
    dmemWEN = 1; dmemaddr = 32'h100; dmemstore = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      if ({ram_wen, ram_ren} !== 2'b10) begin bad++; $display("FAIL pri_wen cyc%0d got=%b want=10", i, {ram_wen, ram_ren}); end
      total++;
      if ({ram_addr, ram_store} !== {32'h100, 32'hDEAD_BEEF}) begin
        bad++; $display("FAIL pri_req cyc%0d addr=%h store=%h want 100/deadbeef", i, ram_addr, ram_store);
      end
      total++;
      if (i == 2) begin ram_ready = 1; ram_load = 32'h5555_5555; end
      tick();
    end
    if ({dhit, ihit, ram_wen} !== 3'b100) begin bad++; $display("FAIL pri_dhit got=%b want=100", {dhit, ihit, ram_wen}); end
    total++;
    if (dmemload !== 32'h0) begin bad++; $display("FAIL pri_wr_load got=%h want=0", dmemload); end
    total++;
    dmemWEN = 0; ram_ready = 0;
    tick();  // one IDLE cycle
    if ({dhit, ihit, ram_ren, ram_wen} !== 4'b0000) begin bad++; $display("FAIL pri_idle got=%b want=0000", {dhit, ihit, ram_ren, ram_wen}); end
    total++;
    tick();  // fetch access starts
    if ({ram_ren, ram_addr} !== {1'b1, 32'h8}) begin bad++; $display("FAIL pri_fetch ren=%b addr=%h want 1/8", ram_ren, ram_addr); end
    total++;
    ram_ready = 1; ram_load = 32'h1234_5678;
    tick();
    if ({ihit, imemload} !== {1'b1, 32'h1234_5678}) begin bad++; $display("FAIL pri_ihit ihit=%b load=%h want 1/12345678", ihit, imemload); end
    total++;
    imemREN = 0; ram_ready = 0;
    tick();
  endtask

  task automatic test_mid_change();
    dmemREN = 1; dmemaddr = 32'h200;
    tick();
    if ({ram_ren, ram_addr} !== {1'b1, 32'h200}) begin bad++; $display("FAIL mid_start ren=%b addr=%h want 1/200", ram_ren, ram_addr); end
    total++;
    dmemaddr = 32'h300;
    tick();
    if (ram_addr !== 32'h200) begin bad++; $display("FAIL mid_hold got=%h want=00000200", ram_addr); end
    total++;
    // Tiny RAM: returns a word that identifies the address presented.
    ram_ready = 1;
    ram_load  = (ram_addr == 32'h200) ? 32'h2222_0200 : 32'h3333_0300;
    tick();
    if ({dhit, dmemload} !== {1'b1, 32'h2222_0200}) begin bad++; $display("FAIL mid_data dhit=%b load=%h want 1/22220200", dhit, dmemload); end
    total++;
    dmemREN = 0; ram_ready = 0;
    tick();
  endtask

  task automatic test_halt();
    imemREN = 1; imemaddr = 32'hC;
    tick();  // IACC
    halt = 1; imemREN = 0;  // halt arrives and the request drops mid-access
    tick();
    if ({ram_ren, halted} !== 2'b10) begin bad++; $display("FAIL halt_acc ren_halted got=%b want=10", {ram_ren, halted}); end
    total++;
    ram_ready = 1; ram_load = 32'h0000_ABCD;
    tick();
    if ({ihit, imemload, halted} !== {1'b1, 32'h0000_ABCD, 1'b0}) begin
      bad++; $display("FAIL halt_ihit ihit=%b load=%h halted=%b want 1/0000abcd/0", ihit, imemload, halted);
    end
    total++;
    ram_ready = 0;
    tick();  // IDLE after the hit
    if ({halted, ihit} !== 2'b00) begin bad++; $display("FAIL halt_idle got=%b want=00", {halted, ihit}); end
    total++;
    tick();
    if (halted !== 1'b1) begin bad++; $display("FAIL halt_enter got=%b want=1", halted); end
    total++;
    imemREN = 1; dmemREN = 1; ram_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({ram_ren, ram_wen, ihit, dhit, halted} !== 5'b00001) begin
        bad++; $display("FAIL halt_hold cyc%0d got=%b want=00001", i, {ram_ren, ram_wen, ihit, dhit, halted});
      end
      total++;
    end
    idle_inputs();
    RST = 1'b1;
    #2 RST = 1'b0;
    if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset got=%b want=0", halted); end
    total++;
  endtask

  task automatic test_ibuf();
    // Prime: fetch 0x40 through the RAM.
    imemREN = 1; imemaddr = 32'h40; ram_ready = 1; ram_load = 32'h1111_0040;
    tick();
    tick();
    if ({ihit, imemload} !== {1'b1, 32'h1111_0040}) begin bad++; $display("FAIL ib_prime ihit=%b load=%h want 1/11110040", ihit, imemload); end
    total++;
    imemREN = 0; ram_ready = 0; ram_load = 32'h0;
    tick();
    // Repeat fetch of 0x40 with the RAM not ready.
    imemREN = 1;
    tick();
`ifdef DP_IBUF_EN
    if ({ihit, ram_ren, imemload} !== {2'b10, 32'h1111_0040}) begin
      bad++; $display("FAIL ib_repeat ihit=%b ren=%b load=%h want 1/0/11110040", ihit, ram_ren, imemload);
    end
    total++;
    imemREN = 0;
    tick();
`else
    if ({ihit, ram_ren} !== 2'b01) begin bad++; $display("FAIL ib_repeat ihit_ren got=%b want=01", {ihit, ram_ren}); end
    total++;
    imemREN = 0; ram_ready = 1; ram_load = 32'h1111_0040;
    tick();
    ram_ready = 0;
    tick();
`endif
    // Store to 0x40, then fetch it again: must go to the RAM.
    dmemWEN = 1; dmemaddr = 32'h40; dmemstore = 32'h2222_0040; ram_ready = 1;
    tick();
    if ({ram_wen, ram_addr} !== {1'b1, 32'h40}) begin bad++; $display("FAIL ib_store wen=%b addr=%h want 1/40", ram_wen, ram_addr); end
    total++;
    tick();
    dmemWEN = 0; ram_ready = 0;
    tick();
    imemREN = 1;
    tick();
    if ({ihit, ram_ren} !== 2'b01) begin bad++; $display("FAIL ib_refetch ihit_ren got=%b want=01", {ihit, ram_ren}); end
    total++;
    ram_ready = 1; ram_load = 32'h2222_0040;
    tick();
    if ({ihit, imemload} !== {1'b1, 32'h2222_0040}) begin bad++; $display("FAIL ib_refetch_data ihit=%b load=%h want 1/22220040", ihit, imemload); end
    total++;
    imemREN = 0; ram_ready = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait_fetch();
    test_priority_wait();
    test_mid_change();
    test_halt();
    test_ibuf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dp_mem_responder
